// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader.
// The checksum feature is built only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

  localparam int ADDR_W = 10;
  localparam int IR_W   = 18;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Position of each byte in the 4-byte header that follows SYNC
  localparam logic [1:0] HDR_ADDR_HI = 2'd0;
  localparam logic [1:0] HDR_ADDR_LO = 2'd1;
  localparam logic [1:0] HDR_CNT_HI  = 2'd2;
  localparam logic [1:0] HDR_CNT_LO  = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5
  } state_e;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/prog_word_asm.sv
// Assembles three received bytes {B0[1:0], B1, B2} into one instruction word.
module prog_word_asm
  import prog_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            byte_valid,
  input  logic [7:0]      byte_in,
  output logic            word_ready,
  output logic [IR_W-1:0] word
);

  logic [1:0]      idx_q, idx_d;
  logic [IR_W-9:0] sh_q, sh_d;

  // Shift each byte in; after B1 the register holds {B0[1:0], B1}
  always_comb begin
    idx_d = idx_q;
    sh_d  = sh_q;
    if (clear) begin
      idx_d = 2'd0;
    end else if (byte_valid) begin
      sh_d = {sh_q[IR_W-17:0], byte_in};
      if (idx_q == 2'd2) begin
        idx_d = 2'd0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Byte counter and shift register state
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 2'd0;
      sh_q  <= '0;
    end else begin
      idx_q <= idx_d;
      sh_q  <= sh_d;
    end
  end

  assign word_ready = byte_valid && !clear && (idx_q == 2'd2);
  assign word       = {sh_q, byte_in};

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing 18-bit instructions into program memory.
// Define PROG_LOADER_CHECKSUM_EN to expect and verify a trailing XOR checksum byte.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              PROG_CLK,
  input  logic              PROG_RST,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              PROG_WE,
  output logic [ADDR_W-1:0] PROG_WADDR,
  output logic [IR_W-1:0]   PROG_WDATA,
  output logic              CPU_HOLD,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR
);

  state_e            state_q, state_d;
  logic [1:0]        hdr_idx_q, hdr_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rx_ready_q, rx_ready_d;
  logic              prog_we_q, prog_we_d;
  logic [ADDR_W-1:0] prog_waddr_q, prog_waddr_d;
  logic [IR_W-1:0]   prog_wdata_q, prog_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              load_err_q, load_err_d;
`endif

  logic            accept_s;
  logic            asm_valid_s;
  logic            asm_ready_s;
  logic [IR_W-1:0] asm_word_s;

  assign accept_s    = RX_VALID && rx_ready_q;
  assign asm_valid_s = accept_s && (state_q == DATA);

  prog_word_asm u_word_asm (
    .clk        (PROG_CLK),
    .rst        (PROG_RST),
    .clear      (state_q == IDLE),
    .byte_valid (asm_valid_s),
    .byte_in    (RX_DATA),
    .word_ready (asm_ready_s),
    .word       (asm_word_s)
  );

  // Next-state, counters and registered-output computation
  always_comb begin
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    prog_we_d    = 1'b0;
    prog_waddr_d = prog_waddr_q;
    prog_wdata_d = prog_wdata_q;
    load_done_d  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
    load_err_d   = load_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s && (RX_DATA == SYNC_BYTE)) begin
          state_d   = HDR;
          hdr_idx_d = HDR_ADDR_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d     = 8'h00;
          load_err_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        if (accept_s) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_update(csum_q, RX_DATA);
`endif
          hdr_idx_d = hdr_idx_q + 2'd1;
          case (hdr_idx_q)
            HDR_ADDR_HI: addr_d[ADDR_W-1:8] = RX_DATA[ADDR_W-9:0];
            HDR_ADDR_LO: addr_d[7:0]        = RX_DATA;
            HDR_CNT_HI:  cnt_d[ADDR_W-1:8]  = RX_DATA[ADDR_W-9:0];
            HDR_CNT_LO: begin
              cnt_d[7:0] = RX_DATA;
              state_d    = DATA;
            end
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = HDR;
        end
      end
      DATA: begin
        if (accept_s) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_update(csum_q, RX_DATA);
`endif
          if (asm_ready_s) begin
            state_d      = WRITE;
            prog_we_d    = 1'b1;
            prog_waddr_d = addr_q;
            prog_wdata_d = asm_word_s;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        // cnt holds words remaining minus one, so zero means this was the last
        if (cnt_q == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d     = DONE;
          load_done_d = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q - ADDR_W'(1);
          state_d = DATA;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept_s) begin
          state_d = DONE;
          if (RX_DATA == csum_q) begin
            load_done_d = 1'b1;
          end else begin
            load_err_d = 1'b1;
          end
        end else begin
          state_d = CHK;
        end
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rx_ready_d = (state_d != WRITE) && (state_d != DONE);
    cpu_hold_d = (state_d != IDLE);
  end

  // FSM and output registers
  always_ff @(posedge PROG_CLK) begin
    if (PROG_RST) begin
      state_q      <= IDLE;
      hdr_idx_q    <= 2'd0;
      addr_q       <= '0;
      cnt_q        <= '0;
      rx_ready_q   <= 1'b0;
      prog_we_q    <= 1'b0;
      prog_waddr_q <= '0;
      prog_wdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= 8'h00;
      load_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hdr_idx_q    <= hdr_idx_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      rx_ready_q   <= rx_ready_d;
      prog_we_q    <= prog_we_d;
      prog_waddr_q <= prog_waddr_d;
      prog_wdata_q <= prog_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
      load_err_q   <= load_err_d;
`endif
    end
  end

  assign RX_READY   = rx_ready_q;
  assign PROG_WE    = prog_we_q;
  assign PROG_WADDR = prog_waddr_q;
  assign PROG_WDATA = prog_wdata_q;
  assign CPU_HOLD   = cpu_hold_q;
  assign LOAD_DONE  = load_done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign LOAD_ERR   = load_err_q;
`else
  assign LOAD_ERR   = 1'b0;
`endif

endmodule
